// File: rtl/execute_port2_issue_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// execute_port2_issue_arbiter_pkg
//   Shared definitions for the ALU2 issue arbiter: packet field layout
//   (LSB/width pairs, MSB-first order writeback .. pcr) and the arbiter
//   state encodings.
// ---------------------------------------------------------------------------
package execute_port2_issue_arbiter_pkg;

  localparam int ALU2_PKT_W                   = 133;

  localparam int ALU2_PKT_PCR_LSB             = 0;
  localparam int ALU2_PKT_PCR_W               = 32;
  localparam int ALU2_PKT_FLAGS_REGNAME_LSB   = 32;
  localparam int ALU2_PKT_FLAGS_REGNAME_W     = 4;
  localparam int ALU2_PKT_FLAGS_WB_LSB        = 36;
  localparam int ALU2_PKT_DEST_REGNAME_LSB    = 37;
  localparam int ALU2_PKT_DEST_REGNAME_W      = 6;
  localparam int ALU2_PKT_LOGIC_DEST_LSB      = 43;
  localparam int ALU2_PKT_LOGIC_DEST_W        = 5;
  localparam int ALU2_PKT_DEST_SYSREG_LSB     = 48;
  localparam int ALU2_PKT_SOURCE1_LSB         = 49;
  localparam int ALU2_PKT_SOURCE1_W           = 32;
  localparam int ALU2_PKT_SOURCE0_LSB         = 81;
  localparam int ALU2_PKT_SOURCE0_W           = 32;
  localparam int ALU2_PKT_ADDER_LSB           = 113;
  localparam int ALU2_PKT_SHIFT_LSB           = 114;
  localparam int ALU2_PKT_LOGIC_LSB           = 115;
  localparam int ALU2_PKT_SYS_REG_LSB         = 116;
  localparam int ALU2_PKT_AFE_LSB             = 117;
  localparam int ALU2_PKT_AFE_W               = 4;
  localparam int ALU2_PKT_CMD_LSB             = 121;
  localparam int ALU2_PKT_CMD_W               = 5;
  localparam int ALU2_PKT_COMMIT_TAG_LSB      = 126;
  localparam int ALU2_PKT_COMMIT_TAG_W        = 6;
  localparam int ALU2_PKT_WRITEBACK_LSB       = 132;

  typedef enum logic [1:0] {
    ALU2ARB_RUN    = 2'd0,
    ALU2ARB_DRAIN  = 2'd1,
    ALU2ARB_HALTED = 2'd2
  } alu2arb_state_e;

endpackage

// File: rtl/execute_rr_select.sv
// ---------------------------------------------------------------------------
// execute_rr_select
//   Combinational round-robin picker, shared by the execute-port arbiters.
//   Ports:
//     iREQ   [NUM_REQ]  request vector
//     iPTR   [PTR_W]    highest-priority index this cycle
//     oGRANT [NUM_REQ]  one-hot grant (first request at or after iPTR)
//     oVALID            any request present
//     oIDX   [PTR_W]    index of the granted requester
// ---------------------------------------------------------------------------
module execute_rr_select #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] iREQ,
  input  logic [PTR_W-1:0]   iPTR,
  output logic [NUM_REQ-1:0] oGRANT,
  output logic               oVALID,
  output logic [PTR_W-1:0]   oIDX
);

  int               idx_int;
  logic [PTR_W-1:0] idx;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    oGRANT  = '0;
    oVALID  = 1'b0;
    oIDX    = '0;
    idx_int = 0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap keeps non-power-of-two NUM_REQ correct.
      idx_int = int'(iPTR) + k;
      if (idx_int >= NUM_REQ) idx_int = idx_int - NUM_REQ;
      idx = idx_int[PTR_W-1:0];
      if (!oVALID && iREQ[idx]) begin
        oVALID      = 1'b1;
        oGRANT[idx] = 1'b1;
        oIDX        = idx;
      end
    end
  end

endmodule

// File: rtl/execute_port2_issue_arbiter.sv
// ---------------------------------------------------------------------------
// execute_port2_issue_arbiter
//   Round-robin arbitration of NUM_REQ issue-queue requesters onto the single
//   ALU2 execute port through a one-entry issue register, with lock
//   back-pressure, pipeline flush and a halt/drain handshake.
//   Ports:
//     iCLOCK, iRESET (async, active-high)
//     iFREE_EX                     flush: drop in-flight packet, no acks
//     iREQ_VALID / iREQ_PKT        per-requester valid + flattened packets
//     oREQ_ACK                     same-cycle one-hot accept
//     iHALT_REQ / oHALT_ACK        halt request / halted and empty
//     oEX_ALU2_VALID / _PKT        issue register towards ALU2
//     iEX_ALU2_LOCK                ALU2 back-pressure
//     oPERF_ISSUE_CNT / STALL_CNT  counters, present only when
//                                  MIST1032SA_ALU2_ARB_PERF_EN is defined
// ---------------------------------------------------------------------------
module execute_port2_issue_arbiter
  import execute_port2_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PKT_W   = ALU2_PKT_W,
  parameter int PTR_W   = 2
) (
  input  logic                     iCLOCK,
  input  logic                     iRESET,
  input  logic                     iFREE_EX,
  input  logic [NUM_REQ-1:0]       iREQ_VALID,
  input  logic [NUM_REQ*PKT_W-1:0] iREQ_PKT,
  output logic [NUM_REQ-1:0]       oREQ_ACK,
  input  logic                     iHALT_REQ,
  output logic                     oHALT_ACK,
  output logic                     oEX_ALU2_VALID,
  output logic [PKT_W-1:0]         oEX_ALU2_PKT,
  input  logic                     iEX_ALU2_LOCK,
  output logic [31:0]              oPERF_ISSUE_CNT,
  output logic [31:0]              oPERF_STALL_CNT
);

  alu2arb_state_e     state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               valid_q, valid_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [NUM_REQ-1:0] grant;
  logic               sel_valid;
  logic [PTR_W-1:0]   sel_idx;
  logic               load;

  execute_rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_select (
    .iREQ   (iREQ_VALID),
    .iPTR   (rr_ptr_q),
    .oGRANT (grant),
    .oVALID (sel_valid),
    .oIDX   (sel_idx)
  );

  // Gating with iRESET keeps the combinational ack low while reset is held,
  // so every output reads 0 during reset, not only the registered ones.
  assign load     = !iRESET && (state_q == ALU2ARB_RUN) && !iFREE_EX &&
                    (!valid_q || !iEX_ALU2_LOCK);
  assign oREQ_ACK = load ? grant : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    valid_d  = valid_q;
    pkt_d    = pkt_q;

    if (iFREE_EX) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = sel_valid;
      if (sel_valid) begin
        pkt_d    = iREQ_PKT[int'(sel_idx)*PKT_W +: PKT_W];
        rr_ptr_d = (sel_idx == PTR_W'(NUM_REQ-1)) ? '0 : sel_idx + PTR_W'(1);
      end
    end else if (!iEX_ALU2_LOCK) begin
      // Outside RUN the port still consumes the held packet once unlocked.
      valid_d = 1'b0;
    end

    case (state_q)
      ALU2ARB_RUN: begin
        if (iHALT_REQ) state_d = ALU2ARB_DRAIN;
      end
      ALU2ARB_DRAIN: begin
        if (!iHALT_REQ)                                  state_d = ALU2ARB_RUN;
        else if (!valid_q || !iEX_ALU2_LOCK || iFREE_EX) state_d = ALU2ARB_HALTED;
      end
      ALU2ARB_HALTED: begin
        if (!iHALT_REQ) state_d = ALU2ARB_RUN;
      end
      default: state_d = ALU2ARB_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering. The packet register is
  // reset too (not just valid) because its value is a visible output.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q  <= ALU2ARB_RUN;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      pkt_q    <= pkt_d;
    end
  end

  assign oEX_ALU2_VALID = valid_q;
  assign oEX_ALU2_PKT   = pkt_q;
  assign oHALT_ACK      = (state_q == ALU2ARB_HALTED) && !valid_q;

`ifdef MIST1032SA_ALU2_ARB_PERF_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running wrap at 2^32; flush deliberately does not clear them.
  always_comb begin
    issue_cnt_d = issue_cnt_q + ((|oREQ_ACK) ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + ((valid_q && iEX_ALU2_LOCK) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign oPERF_ISSUE_CNT = issue_cnt_q;
  assign oPERF_STALL_CNT = stall_cnt_q;
`else
  assign oPERF_ISSUE_CNT = '0;
  assign oPERF_STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_execute_port2_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_execute_port2_issue_arbiter
//   Directed bench for execute_port2_issue_arbiter (NUM_REQ=4, PKT_W=133).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   1 unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_execute_port2_issue_arbiter;

  localparam int NUM_REQ = 4;
  localparam int PKT_W   = 133;
  localparam int PTR_W   = 2;

  logic                     iCLOCK = 1'b0;
  logic                     iRESET;
  logic                     iFREE_EX;
  logic [NUM_REQ-1:0]       iREQ_VALID;
  logic [NUM_REQ*PKT_W-1:0] iREQ_PKT;
  logic [NUM_REQ-1:0]       oREQ_ACK;
  logic                     iHALT_REQ;
  logic                     oHALT_ACK;
  logic                     oEX_ALU2_VALID;
  logic [PKT_W-1:0]         oEX_ALU2_PKT;
  logic                     iEX_ALU2_LOCK;
  logic [31:0]              oPERF_ISSUE_CNT;
  logic [31:0]              oPERF_STALL_CNT;

  int n_total = 0;
  int n_pass  = 0;
  int gen     = 0;

  execute_port2_issue_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PKT_W   (PKT_W),
    .PTR_W   (PTR_W)
  ) dut (
    .iCLOCK          (iCLOCK),
    .iRESET          (iRESET),
    .iFREE_EX        (iFREE_EX),
    .iREQ_VALID      (iREQ_VALID),
    .iREQ_PKT        (iREQ_PKT),
    .oREQ_ACK        (oREQ_ACK),
    .iHALT_REQ       (iHALT_REQ),
    .oHALT_ACK       (oHALT_ACK),
    .oEX_ALU2_VALID  (oEX_ALU2_VALID),
    .oEX_ALU2_PKT    (oEX_ALU2_PKT),
    .iEX_ALU2_LOCK   (iEX_ALU2_LOCK),
    .oPERF_ISSUE_CNT (oPERF_ISSUE_CNT),
    .oPERF_STALL_CNT (oPERF_STALL_CNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_ack;
    logic       exp_valid;
    int         exp_src;
  } vec_t;

  vec_t tbl[16];

  // Distinct, generation-tagged packet per requester.
  function automatic logic [PKT_W-1:0] mk_pkt(input int i, input int g);
    logic [PKT_W-1:0] p;
    p          = '0;
    p[31:0]    = 32'hC0DE_0000 + 32'(i * 256 + g);
    p[112:81]  = 32'(g) ^ 32'h5A5A_0F0F;
    p[125:121] = 5'(i + 1);
    p[132]     = 1'b1;
    return p;
  endfunction

  task automatic check(input string name, input logic [PKT_W-1:0] act,
                       input logic [PKT_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] req, input logic lock,
                       input logic flush, input logic halt);
    iREQ_VALID    = req;
    iEX_ALU2_LOCK = lock;
    iFREE_EX      = flush;
    iHALT_REQ     = halt;
    for (int i = 0; i < NUM_REQ; i++) iREQ_PKT[i*PKT_W +: PKT_W] = mk_pkt(i, gen);
  endtask

  task automatic next_cycle();
    @(posedge iCLOCK);
    #1;
  endtask

  // Check ack, issue-register contents and halt ack for the current cycle.
  task automatic expect_out(input string tag, input logic [3:0] ack,
                            input logic valid, input int src, input int g,
                            input logic hack);
    #1;
    check({tag, "_ack"}, PKT_W'(oREQ_ACK), PKT_W'(ack));
    check({tag, "_valid"}, PKT_W'(oEX_ALU2_VALID), PKT_W'(valid));
    if (valid) check({tag, "_pkt"}, oEX_ALU2_PKT, mk_pkt(src, g));
    check({tag, "_halt_ack"}, PKT_W'(oHALT_ACK), PKT_W'(hack));
  endtask

  initial begin
    int exp_issue;
    int exp_stall;

    // Rotation from rr_ptr=0, then drain, then rr_ptr=3 with 4'b1001.
    tbl[0]  = '{4'b1111, 4'b0001, 1'b0, 0};
    tbl[1]  = '{4'b1111, 4'b0010, 1'b1, 0};
    tbl[2]  = '{4'b1111, 4'b0100, 1'b1, 1};
    tbl[3]  = '{4'b1111, 4'b1000, 1'b1, 2};
    tbl[4]  = '{4'b1111, 4'b0001, 1'b1, 3};
    tbl[5]  = '{4'b1111, 4'b0010, 1'b1, 0};
    tbl[6]  = '{4'b1111, 4'b0100, 1'b1, 1};
    tbl[7]  = '{4'b1111, 4'b1000, 1'b1, 2};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 3};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 0};
    tbl[10] = '{4'b0100, 4'b0100, 1'b0, 0};
    tbl[11] = '{4'b1001, 4'b1000, 1'b1, 2};
    tbl[12] = '{4'b1001, 4'b0001, 1'b1, 3};
    tbl[13] = '{4'b1001, 4'b1000, 1'b1, 0};
    tbl[14] = '{4'b0000, 4'b0000, 1'b1, 3};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 0};

    // NOTE: stimulus is driven with blocking assignments from this process,
    // clear of the clock edge, so the DUT never races the bench.
    iRESET = 1'b1;
    drive(4'b1111, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge iCLOCK);
    #1;
    check("rst_ack", PKT_W'(oREQ_ACK), '0);
    check("rst_valid", PKT_W'(oEX_ALU2_VALID), '0);
    check("rst_pkt", oEX_ALU2_PKT, '0);
    check("rst_halt_ack", PKT_W'(oHALT_ACK), '0);
    check("rst_issue_cnt", PKT_W'(oPERF_ISSUE_CNT), '0);
    check("rst_stall_cnt", PKT_W'(oPERF_STALL_CNT), '0);
    iRESET = 1'b0;

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].req, 1'b0, 1'b0, 1'b0);
      expect_out($sformatf("tbl%0d", k), tbl[k].exp_ack, tbl[k].exp_valid,
                 tbl[k].exp_src, 0, 1'b0);
      next_cycle();
    end

    // Lock: requester 2 only, lock for 3 cycles after first issue.
    iRESET = 1'b1;
    #1;
    iRESET = 1'b0;
    gen = 10; drive(4'b0100, 1'b0, 1'b0, 1'b0); expect_out("lk0", 4'b0100, 1'b0, 0, 0, 1'b0);  next_cycle();
    gen = 11; drive(4'b0100, 1'b1, 1'b0, 1'b0); expect_out("lk1", 4'b0000, 1'b1, 2, 10, 1'b0); next_cycle();
    gen = 12; drive(4'b0100, 1'b1, 1'b0, 1'b0); expect_out("lk2", 4'b0000, 1'b1, 2, 10, 1'b0); next_cycle();
    gen = 13; drive(4'b0100, 1'b1, 1'b0, 1'b0); expect_out("lk3", 4'b0000, 1'b1, 2, 10, 1'b0); next_cycle();
    gen = 14; drive(4'b0100, 1'b0, 1'b0, 1'b0); expect_out("lk4", 4'b0100, 1'b1, 2, 10, 1'b0); next_cycle();
    drive(4'b0000, 1'b0, 1'b0, 1'b0); expect_out("lk5", 4'b0000, 1'b1, 2, 14, 1'b0);
`ifdef MIST1032SA_ALU2_ARB_PERF_EN
    exp_issue = 2;
    exp_stall = 3;
`else
    exp_issue = 0;
    exp_stall = 0;
`endif
    check("lk_issue_cnt", PKT_W'(oPERF_ISSUE_CNT), PKT_W'(exp_issue));
    check("lk_stall_cnt", PKT_W'(oPERF_STALL_CNT), PKT_W'(exp_stall));
    next_cycle();
    drive(4'b0000, 1'b0, 1'b0, 1'b0); expect_out("lk6", 4'b0000, 1'b0, 0, 0, 1'b0);  next_cycle();

    // Flush over lock with requests 4'b0110; rr_ptr is 3 and must survive.
    gen = 20;
    drive(4'b0100, 1'b0, 1'b0, 1'b0); expect_out("fl0", 4'b0100, 1'b0, 0, 0, 1'b0);  next_cycle();
    drive(4'b0110, 1'b1, 1'b1, 1'b0); expect_out("fl1", 4'b0000, 1'b1, 2, 20, 1'b0); next_cycle();
    drive(4'b0110, 1'b1, 1'b0, 1'b0); expect_out("fl2", 4'b0010, 1'b0, 0, 0, 1'b0);  next_cycle();
    drive(4'b0000, 1'b0, 1'b0, 1'b0); expect_out("fl3", 4'b0000, 1'b1, 1, 20, 1'b0); next_cycle();
`ifdef MIST1032SA_ALU2_ARB_PERF_EN
    // Flush leaves counters alone: acks lk0, lk4, fl0, fl2; stalls lk1..3, fl1.
    check("fl_issue_cnt", PKT_W'(oPERF_ISSUE_CNT), PKT_W'(4));
    check("fl_stall_cnt", PKT_W'(oPERF_STALL_CNT), PKT_W'(4));
`endif

    // Halt / drain handshake.
    gen = 30;
    drive(4'b0001, 1'b0, 1'b0, 1'b0); expect_out("ht0", 4'b0001, 1'b0, 0, 0, 1'b0);  next_cycle();
    drive(4'b0001, 1'b1, 1'b0, 1'b1); expect_out("ht1", 4'b0000, 1'b1, 0, 30, 1'b0); next_cycle();
    drive(4'b0001, 1'b1, 1'b0, 1'b1); expect_out("ht2", 4'b0000, 1'b1, 0, 30, 1'b0); next_cycle();
    drive(4'b0001, 1'b0, 1'b0, 1'b1); expect_out("ht3", 4'b0000, 1'b1, 0, 30, 1'b0); next_cycle();
    drive(4'b0001, 1'b0, 1'b0, 1'b1); expect_out("ht4", 4'b0000, 1'b0, 0, 0, 1'b1);  next_cycle();
    drive(4'b0001, 1'b0, 1'b0, 1'b0); expect_out("ht5", 4'b0000, 1'b0, 0, 0, 1'b1);  next_cycle();
    drive(4'b0001, 1'b0, 1'b0, 1'b0); expect_out("ht6", 4'b0001, 1'b0, 0, 0, 1'b0);  next_cycle();
    // Halt raised then withdrawn while still draining: straight back to RUN.
    drive(4'b0000, 1'b1, 1'b0, 1'b1); expect_out("ht7", 4'b0000, 1'b1, 0, 30, 1'b0); next_cycle();
    drive(4'b0010, 1'b1, 1'b0, 1'b0); expect_out("ht8", 4'b0000, 1'b1, 0, 30, 1'b0); next_cycle();
    drive(4'b0010, 1'b0, 1'b0, 1'b0); expect_out("ht9", 4'b0010, 1'b1, 0, 30, 1'b0); next_cycle();

    // Reset mid-lock with a valid packet (rr_ptr is 2 beforehand).
    gen = 40;
    drive(4'b0100, 1'b0, 1'b0, 1'b0); expect_out("rm0", 4'b0100, 1'b1, 1, 30, 1'b0); next_cycle();
    drive(4'b1111, 1'b1, 1'b0, 1'b0); expect_out("rm1", 4'b0000, 1'b1, 2, 40, 1'b0);
    #2;
    iRESET = 1'b1;
    #1;
    check("rm_rst_ack", PKT_W'(oREQ_ACK), '0);
    check("rm_rst_valid", PKT_W'(oEX_ALU2_VALID), '0);
    check("rm_rst_pkt", oEX_ALU2_PKT, '0);
    check("rm_rst_issue_cnt", PKT_W'(oPERF_ISSUE_CNT), '0);
    check("rm_rst_stall_cnt", PKT_W'(oPERF_STALL_CNT), '0);
    next_cycle();
    iRESET = 1'b0;
    drive(4'b1010, 1'b0, 1'b0, 1'b0); expect_out("rm2", 4'b0010, 1'b0, 0, 0, 1'b0); next_cycle();
    drive(4'b0000, 1'b0, 1'b0, 1'b0); expect_out("rm3", 4'b0000, 1'b1, 1, 40, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
